// File: rtl/pkt_assembly_buffer.sv
// Packet assembly buffer: frames serial words into fixed-size packets and queues them in a FWFT FIFO.
// Optional macro PAD_SHORT_EN: zero-pad and commit short frames instead of flagging them as errors.
module pkt_assembly_buffer #(
  parameter int WORD_W        = 8,
  parameter int WORDS_PER_PKT = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              recv_data,
  input  logic [WORD_W-1:0]                 payload,
  input  logic                              read_data,
  output logic [WORDS_PER_PKT*WORD_W-1:0]   pkt_out,
  output logic                              pkt_out_avail,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              pkt_err,
  output logic                              pkt_drop
);
  localparam int PKT_W = WORDS_PER_PKT * WORD_W;
  localparam int CW    = $clog2(WORDS_PER_PKT + 2);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] ASSEMBLE = 1'b1;

  logic [0:0]        state;
  logic [CW-1:0]     wordcnt;
  logic [WORD_W-1:0] slots [WORDS_PER_PKT];
  logic [PKT_W-1:0]  asm_pkt;
  logic              eof, frame_ok, accept, push, pop, empty;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [PKT_W-1:0]  mem [FIFO_DEPTH];

  assign eof = (state == ASSEMBLE) && !recv_data;

`ifdef PAD_SHORT_EN
  // wordcnt is at least 1 in ASSEMBLE, so anything up to a full packet commits
  assign frame_ok = (wordcnt <= CW'(WORDS_PER_PKT));
`else
  assign frame_ok = (wordcnt == CW'(WORDS_PER_PKT));
`endif

  assign accept = !full || read_data;
  assign push   = eof && frame_ok && accept;
  assign pop    = read_data && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      wordcnt <= '0;
    end else if (eof) begin
      state   <= IDLE;
      wordcnt <= '0;
    end else if (recv_data) begin
      state <= ASSEMBLE;
      // saturate one past a full packet to mark overlong frames
      if (wordcnt <= CW'(WORDS_PER_PKT))
        wordcnt <= wordcnt + 1'b1;
    end
  end

  // wordcnt is 0 in IDLE, so the first word lands in slot 0 without a state check;
  // unfilled slots stay 0 because the buffer is cleared at every frame end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < WORDS_PER_PKT; s++) slots[s] <= '0;
    end else begin
      for (int s = 0; s < WORDS_PER_PKT; s++) begin
        if (eof)
          slots[s] <= '0;
        else if (recv_data && wordcnt == CW'(s))
          slots[s] <= payload;
      end
    end
  end

  // word 0 goes to the most-significant slot
  for (genvar s = 0; s < WORDS_PER_PKT; s++) begin : g_pack
    assign asm_pkt[(WORDS_PER_PKT-1-s)*WORD_W +: WORD_W] = slots[s];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_err  <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      pkt_err  <= eof && !frame_ok;
      pkt_drop <= eof && frame_ok && !accept;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage needs no reset: pkt_out is masked to 0 whenever the queue is empty
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= asm_pkt;
  end

  assign count         = wr_ptr - rd_ptr;
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pkt_out_avail = !empty;
  assign pkt_out       = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/pkt_assembly_buffer.md
Name: pkt_assembly_buffer

Overview:
- Parametrised successor to the port input buffer.
- Assembles framed serial words into fixed-size packets and validates frame length. Queues good packets in an internal FWFT FIFO.
- Reports occupancy, length errors and overflow drops.
- Sits between a router input port's serial link and the switch-fabric arbiter, which pops packets with read_data.

Parameters:
- WORD_W, 8, width of one serial payload word in bits.
- WORDS_PER_PKT, 4, words per packet; must be >= 2.
- FIFO_DEPTH, 4, packet entries in queue; must be a power of 2 and >= 2.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- recv_data  in  1  frame valid; high for each word of a frame, low between frames.
- payload  in  WORD_W  serial word, sampled when recv_data=1.
- read_data  in  1  pop head packet; ignored when empty.
- pkt_out  out  WORDS_PER_PKT*WORD_W  head packet; word 0 in most-significant slot.
- pkt_out_avail  out  1  FIFO non-empty.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- pkt_err  out  1  one-cycle pulse: frame length != WORDS_PER_PKT, frame discarded.
- pkt_drop  out  1  one-cycle pulse: valid frame discarded because FIFO full.

Behaviour:
- Reset (async assert, sync release): FIFO empty, word counter 0, assembly buffer 0. Outputs at reset: pkt_out=0, pkt_out_avail=0, full=0, count=0, pkt_err=0, pkt_drop=0.
- Assembler states:
  - IDLE: wordcnt=0. recv_data=1 stores payload in slot 0, wordcnt=1, goes to ASSEMBLE.
  - ASSEMBLE, recv_data=1: if wordcnt<WORDS_PER_PKT, store payload in slot wordcnt. wordcnt increments and saturates at WORDS_PER_PKT+1 (overlong marker); words beyond WORDS_PER_PKT are not stored.
  - ASSEMBLE, recv_data=0 (end-of-frame cycle): evaluate the frame, clear buffer and wordcnt, return to IDLE. The result registers the same edge.
- End-of-frame evaluation:
  - wordcnt==WORDS_PER_PKT and FIFO accepts: write packet.
  - wordcnt==WORDS_PER_PKT and FIFO cannot accept: pkt_drop=1 next cycle, no write.
  - wordcnt<WORDS_PER_PKT or >WORDS_PER_PKT: pkt_err=1 next cycle, no write. pkt_err takes priority; pkt_drop never asserts for an error frame.
- FIFO accepts a write if !full, or full with read_data=1 in the same cycle (pop and push together, count unchanged).
- Latency: last word at cycle N, recv_data low at N+1, pkt_out_avail/count visible at N+2.
- A new frame may start the cycle after the end-of-frame cycle. Minimum inter-frame gap is 1 cycle.
- FIFO is FWFT: pkt_out shows the head whenever pkt_out_avail=1, and is 0 when empty. read_data pops at the edge.
  - Read when empty: no effect, count stays 0.
  - Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
  - Write and read in the same cycle when empty: write happens, read ignored, count becomes 1.
- count/full/pkt_out_avail are registered-derived and never combinationally dependent on read_data or recv_data.
- Reset mid-frame discards the partial frame and all queued packets, with no pulses.

Optional Feature:
- Macro PAD_SHORT_EN.
- Defined: short frames (1..WORDS_PER_PKT-1 words) are zero-padded in the unfilled slots and committed like valid frames. They follow the pkt_drop rules, and pkt_err asserts only for overlong frames.
- Undefined: short frames are discarded with pkt_err as above.

Test Plan:
- Defaults; send frame 0x11,0x22,0x33,0x44, then recv_data low. Required: pkt_out_avail=1 two cycles after the last word, pkt_out=0x11223344, count=1; read_data pop gives count=0, pkt_out=0.
- Send 5 valid frames back-to-back with 1-cycle gaps and no reads. Required: count reaches 4, full=1; 5th frame gives pkt_drop pulse, count stays 4; pops return frames 1-4 in order.
- Full FIFO, read_data=1 in the end-of-frame cycle of a 5th frame. Required: no pkt_drop, count stays 4, the 5th frame appears after 3 further pops.
- Frame of 3 words 0xAA,0xBB,0xCC. Without PAD_SHORT_EN: pkt_err pulse, count 0. With PAD_SHORT_EN: pkt_out=0xAABBCC00, no pkt_err.
- Frame of 6 words. Required: pkt_err pulse, no write; next 4-word frame accepted correctly.
- Assert reset_n low mid-frame after 2 words with 2 packets queued. Required: all outputs 0 immediately, no pulses; the next 4-word frame assembles cleanly.
